// File: rtl/ascon_byte_loader.sv
// rtl/ascon_byte_loader.sv - byte-serial frame loader for the Ascon core operands and mode
module ascon_byte_loader #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   data_in,
    input  logic         data_valid,
    output logic         data_ready,
    output logic [127:0] reg0_128b,
    output logic [127:0] reg1_128b,
    output logic [127:0] reg2_128b,
    output logic [2:0]   operation_mode,
    output logic         operation_ready,
    output logic         busy,
    output logic         timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    // The abort fires on the idle cycle that would bring the counter to the limit.
    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [2:0]  pend;       // mask bits still to be loaded in this frame
    logic [3:0]  byte_cnt;
    logic [15:0] idle_cnt;
    logic [2:0]  cur;        // one-hot current target register
    logic [2:0]  rest;       // pending targets after the current one
    logic        accept;

    assign data_ready = (state != ISSUE);
    assign busy       = (state != IDLE);
    assign accept     = data_valid && data_ready;

    // Lowest pending mask bit selects the register being shifted (order reg0, reg1, reg2).
    always_comb begin
        cur = 3'b000;
        if (pend[0])
            cur = 3'b001;
        else if (pend[1])
            cur = 3'b010;
        else if (pend[2])
            cur = 3'b100;
        rest = pend & ~cur;
    end

    // Frame FSM: header decode, MSB-first operand shifting, issue pulse and inter-byte timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            pend            <= 3'b000;
            byte_cnt        <= 4'd0;
            idle_cnt        <= 16'd0;
            reg0_128b       <= '0;
            reg1_128b       <= '0;
            reg2_128b       <= '0;
            operation_mode  <= 3'b000;
            operation_ready <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            operation_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && data_in[7]) begin
                        operation_mode <= data_in[2:0];
                        timeout_err    <= 1'b0;
                        pend           <= data_in[6:4];
                        byte_cnt       <= 4'd0;
                        idle_cnt       <= 16'd0;
                        if (data_in[6:4] == 3'b000) begin
                            state           <= ISSUE;
                            operation_ready <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        idle_cnt <= 16'd0;
                        byte_cnt <= byte_cnt + 4'd1;
                        if (cur[0]) reg0_128b <= {reg0_128b[119:0], data_in};
                        if (cur[1]) reg1_128b <= {reg1_128b[119:0], data_in};
                        if (cur[2]) reg2_128b <= {reg2_128b[119:0], data_in};
                        if (byte_cnt == 4'd15) begin
                            pend <= rest;
                            if (rest == 3'b000) begin
                                state           <= ISSUE;
                                operation_ready <= 1'b1;
                            end
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        idle_cnt    <= 16'd0;
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 16'd1;
                    end
                end
                ISSUE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_byte_loader.sv
// tb/tb_ascon_byte_loader.sv - self-checking bench for ascon_byte_loader
module tb_ascon_byte_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   data_in;
    logic         data_valid;
    logic         data_ready;
    logic [127:0] reg0_128b;
    logic [127:0] reg1_128b;
    logic [127:0] reg2_128b;
    logic [2:0]   operation_mode;
    logic         operation_ready;
    logic         busy;
    logic         timeout_err;

    ascon_byte_loader #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .reg0_128b      (reg0_128b),
        .reg1_128b      (reg1_128b),
        .reg2_128b      (reg2_128b),
        .operation_mode (operation_mode),
        .operation_ready(operation_ready),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Count issue pulses as seen at each rising edge.
    always @(posedge clk) pulses <= pulses + (operation_ready ? 1 : 0);

    // Reference model state
    logic [127:0] exp_reg [3];
    logic [2:0]   exp_mode;
    logic         exp_err;
    logic [7:0]   pay [48];
    int           gap [48];

    task automatic send_byte(input logic [7:0] b, output int waits);
        data_in    = b;
        data_valid = 1'b1;
        waits      = 0;
        while (!data_ready && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] hdr, input string name);
        int w;
        int k;
        int n;
        int p0;
        n  = 16 * (int'(hdr[4]) + int'(hdr[5]) + int'(hdr[6]));
        p0 = pulses;
        send_byte(hdr, w);
        for (int i = 0; i < n; i++) begin
            repeat (gap[i]) @(negedge clk);
            send_byte(pay[i], w);
        end
        k = 0;
        for (int r = 0; r < 3; r++)
            if (hdr[4 + r])
                for (int j = 0; j < 16; j++) begin
                    exp_reg[r][127 - 8 * j -: 8] = pay[k];
                    k++;
                end
        exp_mode = hdr[2:0];
        exp_err  = 1'b0;
        checks++;
        if (operation_ready !== 1'b1 || data_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s issue_cycle: ready/data_ready/busy = %b%b%b, want 101", name, operation_ready, data_ready, busy);
        end
        @(negedge clk);
        checks++;
        if (operation_ready !== 1'b0 || busy !== 1'b0 || data_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after_issue: ready/busy/data_ready = %b%b%b, want 001", name, operation_ready, busy, data_ready);
        end
        checks++;
        if (pulses - p0 != 1) begin
            errors++;
            $display("FAIL %s pulse_count: got %0d, want 1", name, pulses - p0);
        end
        checks++;
        if (reg0_128b !== exp_reg[0] || reg1_128b !== exp_reg[1] || reg2_128b !== exp_reg[2]
            || operation_mode !== exp_mode || timeout_err !== exp_err) begin
            errors++;
            $display("FAIL %s operands: r0=%h r1=%h r2=%h m=%b e=%b, want r0=%h r1=%h r2=%h m=%b e=%b",
                     name, reg0_128b, reg1_128b, reg2_128b, operation_mode, timeout_err,
                     exp_reg[0], exp_reg[1], exp_reg[2], exp_mode, exp_err);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; data_valid = 1'b0; data_in = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 3; r++) exp_reg[r] = '0;
        exp_mode = 3'b000; exp_err = 1'b0;
        checks++;
        if (reg0_128b !== 128'h0 || reg1_128b !== 128'h0 || reg2_128b !== 128'h0 || operation_mode !== 3'b000
            || operation_ready !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0 || data_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: mode=%b rdy=%b busy=%b err=%b dr=%b, want 000 0 0 0 1",
                     operation_mode, operation_ready, busy, timeout_err, data_ready);
        end
    endtask

    task automatic test_encrypt;
        for (int i = 0; i < 48; i++) begin pay[i] = 8'(i); gap[i] = 0; end
        run_frame(8'hF1, "encrypt");
        checks++;
        if (reg0_128b !== 128'h000102030405060708090a0b0c0d0e0f || reg2_128b !== 128'h202122232425262728292a2b2c2d2e2f) begin
            errors++;
            $display("FAIL encrypt_literal: r0=%h r2=%h", reg0_128b, reg2_128b);
        end
    endtask

    task automatic test_hash;
        for (int i = 0; i < 48; i++) begin pay[i] = 8'hAA; gap[i] = 0; end
        run_frame(8'hC3, "hash");
    endtask

    task automatic test_rerun;
        run_frame(8'h82, "rerun");
    endtask

    task automatic test_junk;
        int w;
        int p0;
        p0 = pulses;
        send_byte(8'h41, w);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || pulses != p0 || operation_mode !== exp_mode) begin
            errors++;
            $display("FAIL junk: busy=%b pulses=%0d mode=%b, want 0 %0d %b", busy, pulses - p0, operation_mode, 0, exp_mode);
        end
    endtask

    task automatic test_back_to_back;
        int w;
        send_byte(8'h82, w);
        data_in = 8'h81; data_valid = 1'b1;
        checks++;
        if (data_ready !== 1'b0 || operation_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_issue: data_ready=%b ready=%b, want 0 1", data_ready, operation_ready);
        end
        send_byte(8'h81, w);
        checks++;
        if (w != 1 || operation_ready !== 1'b1 || operation_mode !== 3'b001) begin
            errors++;
            $display("FAIL backpressure_accept: waits=%0d ready=%b mode=%b, want 1 1 001", w, operation_ready, operation_mode);
        end
        exp_mode = 3'b001;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int w;
        int p0;
        logic [39:0] part;
        p0 = pulses;
        send_byte(8'h91, w);
        part = '0;
        for (int i = 0; i < 5; i++) begin
            pay[i] = 8'($urandom);
            part = (part << 8) | 40'(pay[i]);
            send_byte(pay[i], w);
        end
        exp_reg[0] = (exp_reg[0] << 40) | {88'h0, part};
        exp_mode = 3'b001;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: busy=%b err=%b after 3 idle, want 1 0", busy, timeout_err);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b1 || pulses != p0 || reg0_128b !== exp_reg[0] || operation_mode !== exp_mode) begin
            errors++;
            $display("FAIL timeout_abort: busy=%b err=%b pulses=%0d r0=%h, want 0 1 0 %h",
                     busy, timeout_err, pulses - p0, reg0_128b, exp_reg[0]);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: err=%b, want 1", timeout_err);
        end
        run_frame(8'h81, "clear_err");
    endtask

    task automatic test_byte_wins;
        for (int i = 0; i < 48; i++) begin pay[i] = 8'($urandom); gap[i] = 0; end
        gap[0] = 3; gap[7] = 3; gap[15] = 3;
        run_frame(8'h94, "byte_wins");
    endtask

    task automatic test_random;
        int w;
        logic [7:0] hdr;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 48; i++) begin
                pay[i] = 8'($urandom);
                gap[i] = $urandom_range(0, 3);
            end
            send_byte(8'($urandom) & 8'h7F, w);
            hdr = 8'h80 | (8'($urandom) & 8'h7F);
            if (f == 0) hdr = 8'h8F;
            run_frame(hdr, "random");
        end
    endtask

    task automatic test_reset_mid_load;
        int w;
        send_byte(8'hF5, w);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom), w);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (reg0_128b !== 128'h0 || reg1_128b !== 128'h0 || reg2_128b !== 128'h0 || operation_mode !== 3'b000
            || operation_ready !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0 || data_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_load: r0=%h mode=%b busy=%b err=%b dr=%b, want 0 000 0 0 1",
                     reg0_128b, operation_mode, busy, timeout_err, data_ready);
        end
        for (int r = 0; r < 3; r++) exp_reg[r] = '0;
        exp_mode = 3'b000;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; data_valid = 1'b0; data_in = 8'h00;
        @(negedge clk);
        test_reset();
        test_encrypt();
        test_hash();
        test_rerun();
        test_junk();
        test_back_to_back();
        test_timeout();
        test_byte_wins();
        test_random();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
